div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Sequential signed 32-bit integer divider: the division counterpart of the Booth multiplier.
//  Sits beside the multiplier in the execute stage and writes the HI/LO pair for DIV.
//  Produces quotient in lo and remainder in hi, using a restoring shift-subtract iteration.
//  It runs on operand magnitudes, then applies a sign fix-up to the result.
//  The control FSM holds the pipeline on busy and releases it on the done pulse.
// PARAMETERS
//  WIDTH  32  operand/result width. The iteration count equals WIDTH.
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      synchronous, active-high
//  start       in   1      one-cycle request. Operands are sampled on the same edge.
//  dividend    in   WIDTH  signed dividend (rs)
//  divisor     in   WIDTH  signed divisor (rt)
//  busy        out  1      high from the cycle after an accepted start until done
//  done        out  1      one-cycle pulse. hi/lo/div_zero are valid from this cycle on.
//  div_zero    out  1      divisor was 0 on the last accepted start. Held until the next start.
//  hi          out  WIDTH  remainder. Sign follows the dividend.
//  lo          out  WIDTH  quotient, truncated toward zero
// BEHAVIOUR
//  Reset, clk and reset: reset is synchronous, active-high; the clock is clk.
//   - Reset has priority over everything, including mid-operation.
//   - On reset: state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0, count=0.
//   - Any in-flight division is discarded.
//  FSM states: IDLE, RUN, FIX.
//   - IDLE, start=1, divisor!=0:
//     latch |dividend| into Q and |divisor| into D; R=0, count=0.
//     Latch neg_q = sign(dividend)^sign(divisor) and neg_r = sign(dividend). Go to RUN.
//   - IDLE, start=1, divisor==0: set div_zero=1 and pulse done next cycle.
//     hi/lo keep their previous values. Stay in IDLE. busy never asserts.
//   - RUN, each cycle: {R,Q} <<= 1; T = R - D, computed in WIDTH+1 bits.
//     If T >= 0, set R=T and Q[0]=1; otherwise Q[0]=0.
//     count++. After WIDTH iterations (count==WIDTH-1 processed), go to FIX.
//   - FIX: lo = neg_q ? -Q : Q; hi = neg_r ? -R : R, both two's complement mod 2^WIDTH.
//     Assert done for one cycle, clear busy, go to IDLE.
//  Latency: start on edge N -> done high in cycle N+WIDTH+2 (34 for WIDTH=32).
//   - busy is high for cycles N+1 .. N+WIDTH+1.
//  start while busy: ignored. The operands are not re-sampled and no error is raised.
//  start in the same cycle as done: accepted, because the FSM is in IDLE that cycle.
//  Magnitudes:
//   - |x| is computed as x[MSB] ? (~x+1) : x, in WIDTH bits unsigned.
//   - -2^31 maps to 0x80000000 unsigned.
//  Overflow -2^31 / -1: lo=0x80000000, hi=0. No flag is raised.
//  |divisor| > |dividend|: lo=0, hi=dividend.
//  hi/lo only change in FIX, or on reset. They are stable outside those points.
// STRUCTURE
//  Shared package (alu_pkg):
//   - DATA_W=32.
//   - div_state_t enum {IDLE, RUN, FIX}.
//   - Shared with the multiplier control so one FSM encoding is used.
//  Sub-module:
//   - abs_neg: combinational conditional two's-complement.
//   - Instantiated for operand magnitudes and for the result fix-up.
//  Everything else stays in this file:
//   - FSM, 6-bit counter.
//   - R, Q, D registers and the WIDTH+1-bit subtractor.
// TESTING
//  100 / 7         -> after 34 cycles: done=1, lo=14, hi=2, div_zero=0
//  -100 / 7        -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2)
//  100 / -7        -> lo=-14, hi=2. -100 / -7 -> lo=14, hi=-2.
//  0x80000000 / -1 -> lo=0x80000000, hi=0
//  5 / 0           -> done at cycle 1, busy never high, div_zero=1, hi/lo unchanged
//  Busy and reset:
//   - Start 100/7, pulse start with 9/3 at cycle 10 -> result is still 14/2.
//   - Assert reset at cycle 20 -> all outputs 0, no done. A fresh start then completes normally.
//  Random signed pairs vs reference model:
//   - lo*divisor+hi==dividend.
//   - |hi|<|divisor|.
//   - sign(hi) in {0, sign(dividend)}.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the sequencer state encoding.
// Used by both the divider and the multiplier control so they agree on states.
// No logic here, only types and constants.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/abs_neg.sv
// Conditional two's-complement: y = neg ? -a : a, modulo 2^W.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  // Negation wraps, so the most negative value maps onto itself as an unsigned magnitude.
  assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/div_seq.sv
// Sequential signed divider: quotient on lo, remainder on hi, restoring shift-subtract.
// Latency: start on edge N gives done in cycle N+WIDTH+2; divide-by-zero gives done in cycle N+1.
// Backpressure: busy holds the pipeline; start is ignored while busy.
module div_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_t       state;
  div_state_t       state_nxt;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic             neg_q;
  logic             neg_r;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  logic             load;
  logic             zero_req;
  logic             run_step;
  logic             fix_step;

  abs_neg #(.W(WIDTH)) u_abs_dvd (.a(dividend), .neg(dividend[WIDTH-1]), .y(dvd_mag));
  abs_neg #(.W(WIDTH)) u_abs_dvs (.a(divisor),  .neg(divisor[WIDTH-1]),  .y(dvs_mag));
  abs_neg #(.W(WIDTH)) u_fix_q   (.a(q_q),      .neg(neg_q),             .y(q_fix));
  abs_neg #(.W(WIDTH)) u_fix_r   (.a(r_q),      .neg(neg_r),             .y(r_fix));

  // State register; reset discards any division in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: a zero divisor is answered straight from IDLE without entering RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (divisor != '0)) state_nxt = RUN;
      RUN:     if (count == LAST)            state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded controls; busy covers RUN and FIX so done lands in the first IDLE cycle.
  always_comb begin
    busy     = (state != IDLE);
    load     = (state == IDLE) && start && (divisor != '0);
    zero_req = (state == IDLE) && start && (divisor == '0);
    run_step = (state == RUN);
    fix_step = (state == FIX);
  end

  // Trial subtraction on the shifted partial remainder, one bit wider so the borrow is the sign.
  always_comb begin
    rem_sh = {r_q, q_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, d_q};
  end

  // Datapath and result registers; hi/lo move only in FIX or on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      count    <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        q_q      <= dvd_mag;
        d_q      <= dvs_mag;
        r_q      <= '0;
        count    <= '0;
        neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        neg_r    <= dividend[WIDTH-1];
        div_zero <= 1'b0;
      end
      if (zero_req) begin
        div_zero <= 1'b1;
        done     <= 1'b1;
      end
      if (run_step) begin
        r_q   <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        q_q   <= {q_q[WIDTH-2:0], ~diff[WIDTH]};
        count <= count + CNT_W'(1);
      end
      if (fix_step) begin
        lo   <= q_fix;
        hi   <= r_fix;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_errors;

  logic [31:0] last_q;
  logic [31:0] last_r;

  div_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic, truncating division, wrapped to 32 bits.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = 32'(sa / sb);
    r  = 32'(sa % sb);
  endtask

  function automatic longint mag(input logic [31:0] x);
    longint s;
    s = longint'($signed(x));
    return (s < 0) ? -s : s;
  endfunction

  // One division; inject>0 pulses a 9/3 start at that cycle count while the op runs.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit now,
                       input int inject, output logic [31:0] olo, output logic [31:0] ohi);
    logic [31:0] eq;
    logic [31:0] er;
    logic [31:0] prod;
    int          lat;
    bit          busy_bad;
    bit          zero;
    zero = (b == 32'd0);
    if (zero) begin
      eq = last_q;
      er = last_r;
    end else begin
      model(a, b, eq, er);
    end
    if (!now) @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = 1;
    busy_bad = 1'b0;
    while (!done && lat < 100) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (lat == inject) begin
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    check("latency",   32'(lat), zero ? 32'd1 : 32'd34);
    check("done",      {31'd0, done}, 32'd1);
    check("busy_run",  {31'd0, busy_bad}, 32'd0);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("div_zero",  {31'd0, div_zero}, {31'd0, zero});
    check("lo",        lo, eq);
    check("hi",        hi, er);
    if (!zero) begin
      prod = lo * b + hi;
      check("identity", prod, a);
      check("rem_mag",  {31'd0, mag(hi) < mag(b)}, 32'd1);
      check("rem_sign", {31'd0, (hi == 32'd0) || (hi[31] == a[31])}, 32'd1);
      last_q = eq;
      last_r = er;
    end
    olo = lo;
    ohi = hi;
  endtask

  logic [31:0] rlo;
  logic [31:0] rhi;
  logic [31:0] ra;
  logic [31:0] rb;
  bit          spurious;

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_q   = 32'd0;
    last_r   = 32'd0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz",   {31'd0, div_zero}, 32'd0);
    check("rst_hi",   hi, 32'd0);
    check("rst_lo",   lo, 32'd0);

    // Directed cases against hand-derived constants.
    do_op(32'd100, 32'd7, 1'b0, 0, rlo, rhi);
    check("d1_lo", rlo, 32'd14);
    check("d1_hi", rhi, 32'd2);
    do_op(-32'sd100, 32'd7, 1'b0, 0, rlo, rhi);
    check("d2_lo", rlo, 32'hFFFF_FFF2);
    check("d2_hi", rhi, 32'hFFFF_FFFE);
    do_op(32'd100, -32'sd7, 1'b0, 0, rlo, rhi);
    check("d3_lo", rlo, 32'hFFFF_FFF2);
    check("d3_hi", rhi, 32'd2);
    do_op(-32'sd100, -32'sd7, 1'b0, 0, rlo, rhi);
    check("d4_lo", rlo, 32'd14);
    check("d4_hi", rhi, 32'hFFFF_FFFE);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, rlo, rhi);
    check("ovf_lo", rlo, 32'h8000_0000);
    check("ovf_hi", rhi, 32'd0);
    do_op(-32'sd5, 32'd100, 1'b0, 0, rlo, rhi);
    check("small_lo", rlo, 32'd0);
    check("small_hi", rhi, 32'hFFFF_FFFB);
    do_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 0, rlo, rhi);
    check("maxneg_lo", rlo, 32'd0);
    check("maxneg_hi", rhi, 32'h7FFF_FFFF);
    do_op(32'd5, 32'd0, 1'b0, 0, rlo, rhi);
    check("dz_lo", rlo, 32'd0);
    check("dz_hi", rhi, 32'h7FFF_FFFF);

    // Start while busy is ignored.
    do_op(32'd100, 32'd7, 1'b0, 10, rlo, rhi);
    check("ign_lo", rlo, 32'd14);
    check("ign_hi", rhi, 32'd2);

    // Start in the done cycle is accepted.
    do_op(32'd1000, 32'd33, 1'b1, 0, rlo, rhi);
    check("b2b_lo", rlo, 32'd30);
    check("b2b_hi", rhi, 32'd10);

    // Reset mid-operation clears everything and suppresses done.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_done", {31'd0, done}, 32'd0);
    check("mr_dz",   {31'd0, div_zero}, 32'd0);
    check("mr_hi",   hi, 32'd0);
    check("mr_lo",   lo, 32'd0);
    last_q   = 32'd0;
    last_r   = 32'd0;
    spurious = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
      @(negedge clk);
    end
    check("mr_quiet", {31'd0, spurious}, 32'd0);
    do_op(32'd100, 32'd7, 1'b0, 0, rlo, rhi);
    check("mr_fresh_lo", rlo, 32'd14);

    // Randomized signed pairs, with a bias toward small magnitudes and zero divisors.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = $urandom;
        1:       ra = 32'($urandom_range(0, 1000));
        2:       ra = -32'($urandom_range(0, 1000));
        default: ra = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      endcase
      case ($urandom_range(0, 4))
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 50));
        2:       rb = -32'($urandom_range(1, 50));
        3:       rb = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
        default: rb = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 70000));
      endcase
      do_op(ra, rb, ($urandom_range(0, 3) == 0), 0, rlo, rhi);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
